// File: rtl/sort_n_iterative_pkg.sv
// Shared types and helpers for the iterative odd-even transposition sorter.
package sort_n_iterative_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sort_n_iterative_cas.sv
// Combinational compare-exchange cell for one adjacent element pair.
module sort_cas_cell #(
  parameter int DATA_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  descending,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic                  swapped
);

  // Ties never swap, so ordering of equal keys is preserved.
  assign swapped = descending ? (a < b) : (a > b);
  assign lo_out  = swapped ? b : a;
  assign hi_out  = swapped ? a : b;

endmodule

// File: rtl/sort_n_iterative.sv
// Iterative sorter: one odd-even transposition phase per clock,
// NUM_ELEMS phases per vector, reports total exchange count.
module sort_n_iterative
  import sort_n_iterative_pkg::*;
#(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_ELEMS  = 4,
  localparam int SWAP_W  = clog2(NUM_ELEMS*(NUM_ELEMS-1)/2 + 1),
  localparam int PHASE_W = clog2(NUM_ELEMS + 1),
  localparam int VEC_W   = NUM_ELEMS*DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_data,
  input  logic              in_descending,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_data,
  output logic [SWAP_W-1:0] out_swaps
);

  state_t               state;
  logic [PHASE_W-1:0]   phase;
  logic [SWAP_W-1:0]    swaps;
  logic [SWAP_W-1:0]    cnt;
  logic                 desc;
  logic [DATA_WIDTH-1:0] work [NUM_ELEMS];
  logic [DATA_WIDTH-1:0] nxt  [NUM_ELEMS];
  logic [DATA_WIDTH-1:0] lo   [NUM_ELEMS-1];
  logic [DATA_WIDTH-1:0] hi   [NUM_ELEMS-1];
  logic [NUM_ELEMS-2:0]  sw_act;
  logic [VEC_W-1:0]      nxt_flat;

  assign in_ready = (state == IDLE) && !rst;

  for (genvar k = 0; k < NUM_ELEMS-1; k++) begin : g_cas
    localparam bit EVEN = (k % 2) == 0;
    logic swp;
    sort_cas_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cas (
      .a          (work[k]),
      .b          (work[k+1]),
      .descending (desc),
      .lo_out     (lo[k]),
      .hi_out     (hi[k]),
      .swapped    (swp)
    );
    assign sw_act[k] = swp & (EVEN ^ phase[0]);
  end

  // Element i pairs rightward when its parity matches the phase parity.
  for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_el
    localparam bit EVEN = (i % 2) == 0;
    logic right;
    assign right = EVEN ^ phase[0];
    if (i == 0) begin : g_first
      assign nxt[i] = right ? lo[i] : work[i];
    end else if (i == NUM_ELEMS-1) begin : g_last
      assign nxt[i] = right ? work[i] : hi[i-1];
    end else begin : g_mid
      assign nxt[i] = right ? lo[i] : hi[i-1];
    end
    assign nxt_flat[i*DATA_WIDTH +: DATA_WIDTH] = nxt[i];
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < NUM_ELEMS-1; k++)
      cnt = cnt + SWAP_W'(sw_act[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_swaps <= '0;
      phase     <= '0;
      swaps     <= '0;
      desc      <= 1'b0;
      for (int i = 0; i < NUM_ELEMS; i++) work[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_ELEMS; i++)
              work[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            desc  <= in_descending;
            swaps <= '0;
            phase <= '0;
            state <= SORT;
          end
        end
        SORT: begin
          for (int i = 0; i < NUM_ELEMS; i++) work[i] <= nxt[i];
          swaps <= swaps + cnt;
          phase <= phase + 1'b1;
          if (phase == PHASE_W'(NUM_ELEMS-1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= nxt_flat;
            out_swaps <= swaps + cnt;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_n_iterative.sv
// Self-checking bench for sort_n_iterative (DATA_WIDTH=3, NUM_ELEMS=4).
module tb_sort_n_iterative;

  localparam int DW = 3;
  localparam int N  = 4;
  localparam int VW = DW*N;

  logic          tb_clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          in_descending;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic [2:0]    out_swaps;

  int n_chk;
  int n_fail;

  sort_n_iterative #(.DATA_WIDTH(DW), .NUM_ELEMS(N)) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_descending (in_descending),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_swaps     (out_swaps)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [VW-1:0] din;
    logic          desc;
    logic [VW-1:0] dexp;
    logic [2:0]    sexp;
  } vec_t;

  function automatic logic [VW-1:0] pk(input int e0, e1, e2, e3);
    return {3'(e3), 3'(e2), 3'(e1), 3'(e0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sort with queue methods, swaps = count of out-of-order pairs.
  task automatic model(input logic [VW-1:0] d, input logic desc,
                       output logic [VW-1:0] od, output logic [2:0] os);
    int q[$];
    int inv;
    q = {};
    for (int i = 0; i < N; i++) q.push_back(int'(d[i*DW +: DW]));
    inv = 0;
    for (int i = 0; i < N; i++)
      for (int j = i+1; j < N; j++)
        if (desc ? (q[i] < q[j]) : (q[i] > q[j])) inv++;
    if (desc) q.rsort(); else q.sort();
    od = '0;
    for (int i = 0; i < N; i++) od[i*DW +: DW] = 3'(q[i]);
    os = 3'(inv);
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!in_ready && t < 30) begin
      @(negedge tb_clk);
      t++;
    end
    if (!in_ready) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  // Accept one vector, measure latency, hold backpressure, then drain.
  task automatic run_vec(input string name, input logic [VW-1:0] d,
                         input logic desc, input int hold,
                         input logic [VW-1:0] dexp, input logic [2:0] sexp);
    int lat;
    logic [VW-1:0] hd;
    logic [2:0] hs;
    @(negedge tb_clk);
    wait_ready(name);
    in_valid      = 1'b1;
    in_data       = d;
    in_descending = desc;
    @(posedge tb_clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge tb_clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 4);
    chk({name, "_data"}, out_data, dexp);
    chk({name, "_swaps"}, out_swaps, sexp);
    hd = out_data;
    hs = out_swaps;
    for (int c = 0; c < hold; c++) begin
      @(negedge tb_clk);
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_data"}, out_data, hd);
      chk({name, "_hold_swaps"}, out_swaps, hs);
      chk({name, "_hold_in_ready"}, in_ready, 0);
    end
    @(negedge tb_clk);
    out_ready = 1'b1;
    @(posedge tb_clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_drain_valid"}, out_valid, 0);
    chk({name, "_drain_in_ready"}, in_ready, 1);
  endtask

  vec_t tbl[6];
  logic [VW-1:0] md, vb, va;
  logic [2:0]    ms;
  logic          rd;
  int            t;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_descending = 1'b0;
    out_ready = 1'b0;

    tbl[0] = '{pk(5,1,7,3), 1'b0, pk(1,3,5,7), 3'd3};
    tbl[1] = '{pk(5,1,7,3), 1'b1, pk(7,5,3,1), 3'd3};
    tbl[2] = '{pk(7,6,5,4), 1'b0, pk(4,5,6,7), 3'd6};
    tbl[3] = '{pk(0,1,2,3), 1'b0, pk(0,1,2,3), 3'd0};
    tbl[4] = '{pk(2,2,2,2), 1'b0, pk(2,2,2,2), 3'd0};
    tbl[5] = '{pk(0,1,2,3), 1'b1, pk(3,2,1,0), 3'd6};

    repeat (3) @(posedge tb_clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    @(negedge tb_clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_swaps", out_swaps, 0);
    chk("rst_in_ready_after", in_ready, 1);

    for (int i = 0; i < 6; i++)
      run_vec($sformatf("tbl%0d", i), tbl[i].din, tbl[i].desc, i % 3,
              tbl[i].dexp, tbl[i].sexp);

    run_vec("backpressure", pk(6,0,3,5), 1'b0, 6, pk(0,3,5,6), 3'd3);

    for (int i = 0; i < 30; i++) begin
      va = VW'($urandom);
      rd = 1'($urandom);
      model(va, rd, md, ms);
      run_vec($sformatf("rand%0d", i), va, rd, int'($urandom_range(0, 3)),
              md, ms);
    end

    // Input changes during SORT must not leak into the result.
    va = pk(4,7,1,2);
    vb = pk(3,3,0,6);
    @(negedge tb_clk);
    wait_ready("stab");
    in_valid = 1'b1;
    in_data = va;
    in_descending = 1'b0;
    @(posedge tb_clk);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge tb_clk);
      chk("stab_in_ready_busy", in_ready, out_valid ? 0 : 0);
      in_data = VW'($urandom);
      in_descending = 1'($urandom);
      t++;
    end
    model(va, 1'b0, md, ms);
    chk("stab_data", out_data, md);
    chk("stab_swaps", out_swaps, ms);
    in_data = vb;
    in_descending = 1'b1;
    out_ready = 1'b1;
    @(posedge tb_clk);
    #1;
    out_ready = 1'b0;
    chk("stab_no_accept_on_drain", out_valid, 0);
    chk("stab_idle_ready", in_ready, 1);
    @(posedge tb_clk);
    #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge tb_clk);
      #1;
      t++;
    end
    chk("stab2_latency", t, 4);
    model(vb, 1'b1, md, ms);
    chk("stab2_data", out_data, md);
    chk("stab2_swaps", out_swaps, ms);
    @(negedge tb_clk);
    out_ready = 1'b1;
    @(negedge tb_clk);
    out_ready = 1'b0;

    // Reset mid-sort discards the in-flight vector.
    wait_ready("rstmid");
    in_valid = 1'b1;
    in_data = pk(7,0,7,0);
    in_descending = 1'b0;
    @(posedge tb_clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b1;
    @(posedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b0;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_out_data", out_data, 0);
    chk("rstmid_out_swaps", out_swaps, 0);
    chk("rstmid_in_ready", in_ready, 1);
    t = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge tb_clk);
      if (out_valid) t++;
    end
    chk("rstmid_no_stale", t, 0);
    run_vec("after_rst", pk(3,0,2,1), 1'b0, 1, pk(0,1,2,3), 3'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
